// File: rtl/hdr_parse_sequencer.sv
// Per-frame sequencer for the Ethernet/IPv4/L4 header parser chain.
// Tracks byte offset, decodes header fields and emits lane windows plus a summary.
module hdr_parse_sequencer #(
  parameter int DATA_WIDTH = 64,
  localparam int LANES = DATA_WIDTH / 8,
  localparam int WW = $clog2(LANES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [LANES-1:0]      s_tkeep,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic                  eth_en,
  output logic                  ip_en,
  output logic                  l4_en,
  output logic [WW-1:0]         eth_lo,
  output logic [WW-1:0]         eth_hi,
  output logic [WW-1:0]         ip_lo,
  output logic [WW-1:0]         ip_hi,
  output logic [WW-1:0]         l4_lo,
  output logic [WW-1:0]         l4_hi,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [1:0]            hdr_class,
  output logic [15:0]           hdr_l4_off,
  output logic [1:0]            hdr_err,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t        state;
  logic [15:0]   offset;
  logic [7:0]    et_hi_r, et_lo_r, proto_r;
  logic [3:0]    ihl_r;
  logic [7:0]    et_hi, et_lo, proto;
  logic [3:0]    ihl;
  logic          acc, is_ip, bad;
  logic          complete, trunc, issue;
  logic [WW-1:0] nb;
  logic [16:0]   beg, fin;
  logic [7:0]    l3end, l4len, hend;
  logic [1:0]    cls, err;
  logic [15:0]   l4o;

  function automatic logic [2*WW:0] win(
    input logic [16:0] rlo,
    input logic [16:0] rhi,
    input logic [16:0] b,
    input logic [16:0] f,
    input logic        a
  );
    logic [16:0] lo, hi;
    lo = (rlo > b) ? rlo : b;
    hi = (rhi < f) ? rhi : f;
    win = '0;
    if (a && lo < hi)
      win = {1'b1, WW'(lo - b), WW'(hi - b)};
  endfunction

  assign s_tready = !(hdr_valid && !hdr_ready);
  assign acc = s_tvalid && s_tready;
  assign beg = {1'b0, offset};
  assign fin = beg + 17'(nb);

  always_comb begin
    nb = '0;
    for (int i = 0; i < LANES; i++)
      nb = nb + WW'(s_tkeep[i]);
  end

  // Fields landing in this beat override the registered copies.
  always_comb begin
    et_hi = et_hi_r;
    et_lo = et_lo_r;
    ihl = ihl_r;
    proto = proto_r;
    for (int i = 0; i < LANES; i++) begin
      if (acc && s_tkeep[i]) begin
        if (beg + 17'(i) == 17'd12)
          et_hi = s_tdata[i*8 +: 8];
        if (beg + 17'(i) == 17'd13)
          et_lo = s_tdata[i*8 +: 8];
        if (beg + 17'(i) == 17'd14)
          ihl = s_tdata[i*8 +: 4];
        if (beg + 17'(i) == 17'd23)
          proto = s_tdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    is_ip = {et_hi, et_lo} == 16'h0800;
    bad = is_ip && (ihl < 4'd5);
    l3end = bad ? 8'd20 : 8'd14 + {2'b0, ihl, 2'b0};
    l4len = 8'd0;
    if (is_ip && !bad) begin
      if (proto == 8'd17)
        l4len = 8'd8;
      else if (proto == 8'd6)
        l4len = 8'd20;
    end
    hend = is_ip ? l3end + l4len : 8'd14;
  end

  assign complete = acc && state != BODY
                 && fin >= 17'(hend);
  assign trunc = acc && s_tlast
              && state != BODY && !complete;
  assign issue = complete || trunc;

  always_comb begin
    cls = 2'd0;
    err = 2'd0;
    l4o = 16'd0;
    if (!complete) begin
      cls = is_ip ? 2'd1 : 2'd0;
      err = 2'd1;
    end else if (is_ip) begin
      cls = 2'd1;
      if (bad) begin
        err = 2'd2;
      end else if (l4len == 8'd8) begin
        cls = 2'd2;
        l4o = {8'd0, l3end};
      end else if (l4len == 8'd20) begin
        cls = 2'd3;
        l4o = {8'd0, l3end};
      end
    end
  end

  assign {eth_en, eth_lo, eth_hi} =
    win(17'd0, 17'd14, beg, fin, acc);
  assign {ip_en, ip_lo, ip_hi} =
    win(17'd14, is_ip ? 17'(l3end) : 17'd14,
        beg, fin, acc);
  assign {l4_en, l4_lo, l4_hi} =
    win(17'(l3end), 17'(l3end) + 17'(l4len),
        beg, fin, acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      offset <= '0;
      et_hi_r <= '0;
      et_lo_r <= '0;
      ihl_r <= '0;
      proto_r <= '0;
    end else if (acc) begin
      if (s_tlast) begin
        state <= IDLE;
        offset <= '0;
        et_hi_r <= '0;
        et_lo_r <= '0;
        ihl_r <= '0;
        proto_r <= '0;
      end else begin
        state <= (complete || state == BODY)
               ? BODY : HDR;
        offset <= fin[16] ? 16'hFFFF : fin[15:0];
        et_hi_r <= et_hi;
        et_lo_r <= et_lo;
        ihl_r <= ihl;
        proto_r <= proto;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_valid <= 1'b0;
      hdr_class <= '0;
      hdr_l4_off <= '0;
      hdr_err <= '0;
      frame_cnt <= '0;
      err_cnt <= '0;
    end else if (issue) begin
      hdr_valid <= 1'b1;
      hdr_class <= cls;
      hdr_l4_off <= l4o;
      hdr_err <= err;
      if (frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (err != 2'd0 && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end else if (hdr_valid && hdr_ready) begin
      hdr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdr_parse_sequencer.sv
// Directed bench for hdr_parse_sequencer at 64b and 512b stream widths.
// Frames are built in a byte array and checked beat by beat.
module tb_hdr_parse_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tlast, s_tready;
  logic        eth_en, ip_en, l4_en;
  logic [3:0]  eth_lo, eth_hi, ip_lo, ip_hi;
  logic [3:0]  l4_lo, l4_hi;
  logic        hdr_valid, hdr_ready;
  logic [1:0]  hdr_class, hdr_err;
  logic [15:0] hdr_l4_off, frame_cnt, err_cnt;

  logic [511:0] s2_tdata;
  logic [63:0]  s2_tkeep;
  logic         s2_tvalid, s2_tlast, s2_tready;
  logic         e2_en, i2_en, l2_en;
  logic [6:0]   e2_lo, e2_hi, i2_lo, i2_hi;
  logic [6:0]   l2_lo, l2_hi;
  logic         h2_valid, h2_ready;
  logic [1:0]   h2_class, h2_err;
  logic [15:0]  h2_l4_off, f2_cnt, r2_cnt;

  logic [7:0] frm [0:127];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hdr_parse_sequencer #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .eth_en(eth_en), .ip_en(ip_en), .l4_en(l4_en),
    .eth_lo(eth_lo), .eth_hi(eth_hi),
    .ip_lo(ip_lo), .ip_hi(ip_hi),
    .l4_lo(l4_lo), .l4_hi(l4_hi),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_class(hdr_class), .hdr_l4_off(hdr_l4_off),
    .hdr_err(hdr_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  hdr_parse_sequencer #(.DATA_WIDTH(512)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s2_tdata), .s_tkeep(s2_tkeep),
    .s_tvalid(s2_tvalid), .s_tlast(s2_tlast),
    .s_tready(s2_tready),
    .eth_en(e2_en), .ip_en(i2_en), .l4_en(l2_en),
    .eth_lo(e2_lo), .eth_hi(e2_hi),
    .ip_lo(i2_lo), .ip_hi(i2_hi),
    .l4_lo(l2_lo), .l4_hi(l2_hi),
    .hdr_valid(h2_valid), .hdr_ready(h2_ready),
    .hdr_class(h2_class), .hdr_l4_off(h2_l4_off),
    .hdr_err(h2_err),
    .frame_cnt(f2_cnt), .err_cnt(r2_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [15:0] et,
                       input logic [3:0] ihl,
                       input logic [7:0] pr);
    for (int i = 0; i < 128; i++) frm[i] = 8'(i);
    frm[12] = et[15:8];
    frm[13] = et[7:0];
    frm[14] = {4'h4, ihl};
    frm[23] = pr;
  endtask

  task automatic set_beat(input int b, input int len);
    s_tvalid = 1'b1;
    s_tlast = ((b + 1) * 8 >= len);
    for (int i = 0; i < 8; i++) begin
      s_tdata[i*8 +: 8] = frm[b*8 + i];
      s_tkeep[i] = (b * 8 + i < len);
    end
    #3;
  endtask

  initial begin
    rst_n = 1'b0;
    s_tdata = '0; s_tkeep = '0;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    s2_tdata = '0; s2_tkeep = '0;
    s2_tvalid = 1'b0; s2_tlast = 1'b0;
    hdr_ready = 1'b1; h2_ready = 1'b1;
    #12 rst_n = 1'b1;
    tick;
    chk("rst_valid", 32'(hdr_valid), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_ready", 32'(s_tready), 32'd1);
    chk("rst_eth", 32'({eth_en, eth_lo, eth_hi}), 32'd0);

    // UDP IHL5, 60 bytes
    build(16'h0800, 4'd5, 8'd17);
    set_beat(0, 60);
    chk("udp_b0_eth", 32'({eth_en, eth_lo, eth_hi}), 32'({1'b1, 4'd0, 4'd8}));
    chk("udp_b0_ip", 32'(ip_en), 32'd0);
    tick;
    set_beat(1, 60);
    chk("udp_b1_eth", 32'({eth_en, eth_lo, eth_hi}), 32'({1'b1, 4'd0, 4'd6}));
    chk("udp_b1_ip", 32'({ip_en, ip_lo, ip_hi}), 32'({1'b1, 4'd6, 4'd8}));
    tick;
    set_beat(2, 60); tick;
    set_beat(3, 60); tick;
    set_beat(4, 60);
    chk("udp_b4_ip", 32'({ip_en, ip_lo, ip_hi}), 32'({1'b1, 4'd0, 4'd2}));
    chk("udp_b4_l4", 32'({l4_en, l4_lo, l4_hi}), 32'({1'b1, 4'd2, 4'd8}));
    tick;
    set_beat(5, 60);
    chk("udp_b5_l4", 32'({l4_en, l4_lo, l4_hi}), 32'({1'b1, 4'd0, 4'd2}));
    chk("udp_b5_noval", 32'(hdr_valid), 32'd0);
    tick;
    chk("udp_valid", 32'(hdr_valid), 32'd1);
    chk("udp_class", 32'(hdr_class), 32'd2);
    chk("udp_off", 32'(hdr_l4_off), 32'd34);
    chk("udp_err", 32'(hdr_err), 32'd0);
    set_beat(6, 60);
    chk("udp_body_en", 32'({eth_en, ip_en, l4_en}), 32'd0);
    tick;
    chk("udp_drop", 32'(hdr_valid), 32'd0);
    set_beat(7, 60); tick;
    s_tvalid = 1'b0;
    chk("udp_cnt", 32'(frame_cnt), 32'd1);

    // TCP IHL6, 70 bytes
    build(16'h0800, 4'd6, 8'd6);
    for (int b = 0; b < 4; b++) begin
      set_beat(b, 70); tick;
    end
    set_beat(4, 70);
    chk("tcp_b4_ip", 32'({ip_en, ip_lo, ip_hi}), 32'({1'b1, 4'd0, 4'd6}));
    chk("tcp_b4_l4", 32'({l4_en, l4_lo, l4_hi}), 32'({1'b1, 4'd6, 4'd8}));
    tick;
    set_beat(5, 70); tick;
    set_beat(6, 70); tick;
    set_beat(7, 70);
    chk("tcp_b7_l4", 32'({l4_en, l4_lo, l4_hi}), 32'({1'b1, 4'd0, 4'd2}));
    tick;
    chk("tcp_class", 32'(hdr_class), 32'd3);
    chk("tcp_off", 32'(hdr_l4_off), 32'd38);
    chk("tcp_err", 32'(hdr_err), 32'd0);
    set_beat(8, 70); tick;
    s_tvalid = 1'b0;

    // ARP with an empty-keep beat in the middle
    build(16'h0806, 4'd5, 8'd17);
    set_beat(0, 60); tick;
    s_tkeep = '0; s_tlast = 1'b0;
    #3;
    chk("arp_k0_en", 32'({eth_en, ip_en, l4_en}), 32'd0);
    tick;
    set_beat(1, 60);
    chk("arp_b1_eth", 32'({eth_en, eth_lo, eth_hi}), 32'({1'b1, 4'd0, 4'd6}));
    chk("arp_b1_ip", 32'(ip_en), 32'd0);
    tick;
    chk("arp_valid", 32'(hdr_valid), 32'd1);
    chk("arp_class", 32'(hdr_class), 32'd0);
    chk("arp_err", 32'(hdr_err), 32'd0);
    for (int b = 2; b < 8; b++) begin
      set_beat(b, 60); tick;
    end
    s_tvalid = 1'b0;

    // IPv4 truncated at byte 24
    build(16'h0800, 4'd5, 8'd17);
    for (int b = 0; b < 3; b++) begin
      set_beat(b, 24); tick;
    end
    s_tvalid = 1'b0;
    chk("trunc_class", 32'(hdr_class), 32'd1);
    chk("trunc_err", 32'(hdr_err), 32'd1);
    chk("trunc_ecnt", 32'(err_cnt), 32'd1);
    chk("trunc_fcnt", 32'(frame_cnt), 32'd4);

    // IHL 3: bad header, completes at byte 20
    build(16'h0800, 4'd3, 8'd17);
    set_beat(0, 40); tick;
    set_beat(1, 40); tick;
    set_beat(2, 40);
    chk("bad_b2_ip", 32'({ip_en, ip_lo, ip_hi}), 32'({1'b1, 4'd0, 4'd4}));
    chk("bad_b2_l4", 32'(l4_en), 32'd0);
    tick;
    chk("bad_class", 32'(hdr_class), 32'd1);
    chk("bad_err", 32'(hdr_err), 32'd2);
    chk("bad_off", 32'(hdr_l4_off), 32'd0);
    chk("bad_ecnt", 32'(err_cnt), 32'd2);
    set_beat(3, 40); tick;
    set_beat(4, 40); tick;
    s_tvalid = 1'b0;

    // Backpressure: summary unconsumed stalls the next frame
    hdr_ready = 1'b0;
    build(16'h0800, 4'd5, 8'd17);
    for (int b = 0; b < 6; b++) begin
      set_beat(b, 42); tick;
    end
    s_tvalid = 1'b0;
    #1;
    chk("bp_valid", 32'(hdr_valid), 32'd1);
    chk("bp_ready", 32'(s_tready), 32'd0);
    build(16'h0806, 4'd5, 8'd0);
    set_beat(0, 60);
    chk("bp_stall_en", 32'(eth_en), 32'd0);
    tick;
    chk("bp_hold_cls", 32'(hdr_class), 32'd2);
    tick;
    chk("bp_hold_off", 32'(hdr_l4_off), 32'd34);
    chk("bp_hold_val", 32'(hdr_valid), 32'd1);
    hdr_ready = 1'b1;
    #1;
    chk("bp_release", 32'(s_tready), 32'd1);
    chk("bp_rel_eth", 32'({eth_en, eth_lo, eth_hi}), 32'({1'b1, 4'd0, 4'd8}));
    tick;
    set_beat(1, 60); tick;
    chk("bp2_valid", 32'(hdr_valid), 32'd1);
    chk("bp2_class", 32'(hdr_class), 32'd0);
    for (int b = 2; b < 8; b++) begin
      set_beat(b, 60); tick;
    end
    s_tvalid = 1'b0;
    chk("bp_fcnt", 32'(frame_cnt), 32'd7);

    // 512b single-beat TCP
    build(16'h0800, 4'd5, 8'd6);
    for (int i = 0; i < 64; i++)
      s2_tdata[i*8 +: 8] = frm[i];
    s2_tkeep = '1;
    s2_tlast = 1'b1;
    s2_tvalid = 1'b1;
    #3;
    chk("w_eth", 32'({e2_en, e2_lo, e2_hi}), 32'({1'b1, 7'd0, 7'd14}));
    chk("w_ip", 32'({i2_en, i2_lo, i2_hi}), 32'({1'b1, 7'd14, 7'd34}));
    chk("w_l4", 32'({l2_en, l2_lo, l2_hi}), 32'({1'b1, 7'd34, 7'd54}));
    tick;
    s2_tvalid = 1'b0;
    chk("w_class", 32'(h2_class), 32'd3);
    chk("w_off", 32'(h2_l4_off), 32'd34);
    chk("w_fcnt", 32'(f2_cnt), 32'd1);

    // Reset mid-frame
    build(16'h0806, 4'd5, 8'd0);
    set_beat(0, 60); tick;
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
    chk("mrst_ecnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick;
    set_beat(0, 60);
    chk("mrst_eth", 32'({eth_en, eth_lo, eth_hi}), 32'({1'b1, 4'd0, 4'd8}));
    tick;
    s_tvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
